// File: rtl/vdc_video_shifter_pkg.sv
// Shared constants and types for the VDC video shifter.
package vdc_video_shifter_pkg;

    localparam int unsigned ATTR_ALT   = 7;
    localparam int unsigned ATTR_RVS   = 6;
    localparam int unsigned ATTR_UL    = 5;
    localparam int unsigned ATTR_BLINK = 4;

    typedef enum logic [1:0] {
        CM_SOLID   = 2'b00,
        CM_OFF     = 2'b01,
        CM_BLINK16 = 2'b10,
        CM_BLINK32 = 2'b11
    } cursor_mode_e;

    typedef logic [3:0] rgbi_t;

endpackage

// File: rtl/vdc_video_shifter_if.sv
// Timing, latch and register bundle between the VDC core and its video shifter.
interface vdc_video_shifter_if #(
    parameter int unsigned A_LATCH_WIDTH = 80,
    parameter int unsigned C_LATCH_WIDTH = 8
) ();
    import vdc_video_shifter_pkg::*;

    logic         enable;
    logic [1:0]   newFrame;
    logic         newCol;
    logic [7:0]   col;
    logic [4:0]   line;
    logic [1:0]   visible;
    logic         rowbuf;
    logic [7:0]   attrbuf [2][A_LATCH_WIDTH];
    logic [7:0]   charbuf [C_LATCH_WIDTH];
    logic [15:0]  dispaddr;
    logic [3:0]   reg_cth;
    logic [3:0]   reg_cdh;
    logic [3:0]   reg_hss;
    rgbi_t        reg_fg;
    rgbi_t        reg_bg;
    logic         reg_rvs;
    logic         reg_atr;
    logic         reg_text;
    logic         reg_semi;
    logic         reg_dbl;
    logic         reg_cbrate;
    cursor_mode_e reg_cm;
    logic [4:0]   reg_crs;
    logic [4:0]   reg_cre;
    logic [15:0]  reg_cp;
    logic [4:0]   reg_ul;
    rgbi_t        rgbi;
    logic         active;

    modport master (
        output enable, newFrame, newCol, col, line, visible, rowbuf, attrbuf, charbuf, dispaddr,
               reg_cth, reg_cdh, reg_hss, reg_fg, reg_bg, reg_rvs, reg_atr, reg_text, reg_semi,
               reg_dbl, reg_cbrate, reg_cm, reg_crs, reg_cre, reg_cp, reg_ul,
        input  rgbi, active
    );

    modport slave (
        input  enable, newFrame, newCol, col, line, visible, rowbuf, attrbuf, charbuf, dispaddr,
               reg_cth, reg_cdh, reg_hss, reg_fg, reg_bg, reg_rvs, reg_atr, reg_text, reg_semi,
               reg_dbl, reg_cbrate, reg_cm, reg_crs, reg_cre, reg_cp, reg_ul,
        output rgbi, active
    );

endinterface

// File: rtl/vdc_video_shifter_blink.sv
// Frame counter producing the character and cursor blink phases.
module vdc_blink
    import vdc_video_shifter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         frame_tick,
    input  logic         cbrate,
    input  cursor_mode_e cm,
    output logic         char_phase,
    output logic         curs_phase
);

    logic [5:0] frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (enable && frame_tick) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign char_phase = cbrate ? frame_cnt[5] : frame_cnt[4];
    assign curs_phase = cm[0]  ? frame_cnt[4] : frame_cnt[3];

endmodule

// File: rtl/vdc_video_shifter.sv
// Pixel back-end of the VDC: latches one glyph/bitmap byte per character column and
// serialises it to RGBI with attribute, cursor, blink, doubling and smooth-scroll handling.
module vdc_video_shifter
    import vdc_video_shifter_pkg::*;
#(
    parameter int unsigned S_LATCH_WIDTH = 80,
    parameter int unsigned A_LATCH_WIDTH = 80,
    parameter int unsigned C_LATCH_WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    vdc_video_shifter_if.slave bus
);

    // Attributes only exist for columns that also hold a screen code.
    localparam int unsigned A_DEPTH = (A_LATCH_WIDTH < S_LATCH_WIDTH) ? A_LATCH_WIDTH : S_LATCH_WIDTH;
    localparam int unsigned AW      = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned CW      = (C_LATCH_WIDTH > 1) ? $clog2(C_LATCH_WIDTH) : 1;

    logic [7:0]    c;
    logic [AW-1:0] a_idx;
    logic [CW-1:0] c_idx;
    logic [6:0]    attr_d;
    logic          curs_d;
    logic          cm_allow;
    logic          char_phase;
    logic          curs_phase;

    logic [7:0]    shreg;
    logic [6:0]    attr_q;
    logic          curs_q;
    logic          win_q;
    logic          hold_q;
    logic [3:0]    pcnt;
    logic [3:0]    hss_q;
    rgbi_t         dly_rgbi [16];
    logic          dly_act  [16];

    logic          p;
    rgbi_t         pix_rgbi;

    vdc_blink u_blink (
        .clk        (clk),
        .reset      (reset),
        .enable     (bus.enable),
        .frame_tick (bus.newFrame[0]),
        .cbrate     (bus.reg_cbrate),
        .cm         (bus.reg_cm),
        .char_phase (char_phase),
        .curs_phase (curs_phase)
    );

    // The column being loaded was fetched during the previous column.
    assign c      = bus.col - 8'd1;
    assign a_idx  = AW'(32'(c) % A_DEPTH);
    assign c_idx  = CW'(32'(c) % C_LATCH_WIDTH);
    assign attr_d = bus.reg_atr ? bus.attrbuf[bus.rowbuf][a_idx][6:0] : {3'b000, bus.reg_fg};

    always_comb begin
        cm_allow = 1'b0;
        case (bus.reg_cm)
            CM_SOLID: cm_allow = 1'b1;
            CM_OFF:   cm_allow = 1'b0;
            default:  cm_allow = !curs_phase;
        endcase
    end

    assign curs_d = cm_allow && ((bus.dispaddr + {8'h00, c}) == bus.reg_cp) &&
                    (bus.line >= bus.reg_crs) && (bus.line < bus.reg_cre);

    always_comb begin
        p = shreg[7];
        if (attr_q[ATTR_UL] && !bus.reg_text && (bus.line == bus.reg_ul)) p = 1'b1;
        if (attr_q[ATTR_BLINK] && char_phase) p = 1'b0;
        p = p ^ attr_q[ATTR_RVS] ^ bus.reg_rvs ^ curs_q;
        pix_rgbi = p ? attr_q[3:0] : bus.reg_bg;
        if (!win_q || (pcnt > bus.reg_cdh) || ((pcnt > 4'd7) && !bus.reg_semi)) pix_rgbi = bus.reg_bg;
    end

    // The shift refills with bit 0 so the semigraphics tail keeps emitting it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg  <= '0;
            attr_q <= '0;
            curs_q <= 1'b0;
            win_q  <= 1'b0;
            hold_q <= 1'b0;
            pcnt   <= '0;
            hss_q  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                dly_rgbi[i] <= '0;
                dly_act[i]  <= 1'b0;
            end
        end else if (bus.enable) begin
            dly_rgbi[0] <= pix_rgbi;
            dly_act[0]  <= win_q;
            for (int unsigned i = 1; i < 16; i++) begin
                dly_rgbi[i] <= dly_rgbi[i-1];
                dly_act[i]  <= dly_act[i-1];
            end
            if (bus.newCol) begin
                shreg  <= bus.charbuf[c_idx];
                attr_q <= attr_d;
                curs_q <= curs_d;
                win_q  <= bus.visible[0] && bus.visible[1];
                hold_q <= 1'b0;
                pcnt   <= '0;
                hss_q  <= bus.reg_hss;
            end else if (bus.reg_dbl && !hold_q) begin
                hold_q <= 1'b1;
            end else begin
                hold_q <= 1'b0;
                shreg  <= {shreg[6:0], shreg[0]};
                if (pcnt < bus.reg_cth) pcnt <= pcnt + 4'd1;
            end
        end
    end

    assign bus.rgbi   = dly_rgbi[hss_q];
    assign bus.active = dly_act[hss_q];

endmodule

// File: tb/tb_vdc_video_shifter.sv
// Randomised and directed bench for vdc_video_shifter against a per-pixel reference model.
module tb_vdc_video_shifter;
    import vdc_video_shifter_pkg::*;

    localparam int unsigned A_W = 80;
    localparam int unsigned C_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdc_video_shifter_if #(.A_LATCH_WIDTH(A_W), .C_LATCH_WIDTH(C_W)) bus ();

    vdc_video_shifter #(
        .S_LATCH_WIDTH (80),
        .A_LATCH_WIDTH (A_W),
        .C_LATCH_WIDTH (C_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: column descriptor plus count of pixel advances since load.
    logic [7:0] m_byte;
    logic [7:0] m_attr;
    bit         m_curs, m_win, m_valid;
    int         m_k, m_hss, m_fcnt;
    logic [4:0] hist [$];
    logic [3:0] pat  [$];

    function automatic logic [4:0] model_pixel();
        int n;
        bit p;
        if (!m_valid || !m_win) return {1'b0, bus.reg_bg};
        n = bus.reg_dbl ? m_k / 2 : m_k;
        if (n > int'(bus.reg_cth)) n = int'(bus.reg_cth);
        if (n > int'(bus.reg_cdh) || (n >= 8 && !bus.reg_semi)) return {1'b1, bus.reg_bg};
        p = (n < 8) ? m_byte[7 - n] : m_byte[0];
        if (m_attr[5] && !bus.reg_text && bus.line == bus.reg_ul) p = 1'b1;
        if (m_attr[4] && (((m_fcnt >> (4 + int'(bus.reg_cbrate))) & 1) == 1)) p = 1'b0;
        p = p ^ m_attr[6] ^ bus.reg_rvs ^ m_curs;
        return {1'b1, p ? m_attr[3:0] : bus.reg_bg};
    endfunction

    function automatic void model_load();
        int c;
        bit allow;
        c      = (int'(bus.col) + 255) % 256;
        m_byte = bus.charbuf[c % C_W];
        m_attr = bus.reg_atr ? bus.attrbuf[bus.rowbuf][c % A_W] : {4'h0, bus.reg_fg};
        case (bus.reg_cm)
            CM_SOLID:   allow = 1'b1;
            CM_OFF:     allow = 1'b0;
            CM_BLINK16: allow = ((m_fcnt >> 3) & 1) == 0;
            default:    allow = ((m_fcnt >> 4) & 1) == 0;
        endcase
        m_curs  = allow && (((int'(bus.dispaddr) + c) % 65536) == int'(bus.reg_cp)) &&
                  (bus.line >= bus.reg_crs) && (bus.line < bus.reg_cre);
        m_win   = (bus.visible == 2'b11);
        m_valid = 1'b1;
        m_k     = 0;
        m_hss   = int'(bus.reg_hss);
    endfunction

    task automatic step(input bit en, input bit ncol, input bit nframe);
        logic [4:0] e;
        @(negedge clk);
        bus.enable   = en;
        bus.newCol   = ncol;
        bus.newFrame = {1'($urandom_range(0, 1)), nframe};
        @(posedge clk);
        if (en) begin
            hist.push_back(model_pixel());
            if (ncol) model_load();
            else m_k++;
            if (nframe) m_fcnt = (m_fcnt + 1) % 64;
        end
        #1;
        e = (hist.size() > m_hss) ? hist[hist.size() - 1 - m_hss] : 5'h00;
        check_eq("rgbi", bus.rgbi, e[3:0]);
        check_eq("active", bus.active, e[4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.enable = 1'b0;
        bus.newCol = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("reset_rgbi", bus.rgbi, 4'h0);
        check_eq("reset_active", bus.active, 1'b0);
        hist.delete();
        m_valid = 1'b0; m_win = 1'b0; m_curs = 1'b0;
        m_k = 0; m_hss = 0; m_fcnt = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One column with a fixed expected pixel list, checked after the scroll delay.
    task automatic directed(input string tag, input logic [7:0] byte_v);
        int len;
        int hss;
        len = pat.size();
        hss = int'(bus.reg_hss);
        bus.charbuf[((int'(bus.col) + 255) % 256) % C_W] = byte_v;
        step(1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= len + hss; j++) begin
            step(1'b1, 1'b0, 1'b0);
            if (j - 1 - hss >= 0) check_eq(tag, bus.rgbi, pat[j - 1 - hss]);
        end
    endtask

    task automatic make_pat(input logic [7:0] b, input int rep, input logic [3:0] on_c, input logic [3:0] off_c);
        pat.delete();
        for (int i = 7; i >= 0; i--)
            for (int r = 0; r < rep; r++) pat.push_back(b[i] ? on_c : off_c);
    endtask

    task automatic set_defaults();
        bus.enable = 1'b0; bus.newFrame = 2'b00; bus.newCol = 1'b0;
        bus.col = 8'd1; bus.line = 5'd0; bus.visible = 2'b11; bus.rowbuf = 1'b0;
        bus.dispaddr = 16'h0000;
        for (int i = 0; i < int'(A_W); i++) begin
            bus.attrbuf[0][i] = 8'h00;
            bus.attrbuf[1][i] = 8'h00;
        end
        for (int i = 0; i < int'(C_W); i++) bus.charbuf[i] = 8'h00;
        bus.reg_cth = 4'd7; bus.reg_cdh = 4'd7; bus.reg_hss = 4'd0;
        bus.reg_fg = 4'hF; bus.reg_bg = 4'h0;
        bus.reg_rvs = 1'b0; bus.reg_atr = 1'b0; bus.reg_text = 1'b1; bus.reg_semi = 1'b0;
        bus.reg_dbl = 1'b0; bus.reg_cbrate = 1'b0; bus.reg_cm = CM_OFF;
        bus.reg_crs = 5'd0; bus.reg_cre = 5'd0; bus.reg_cp = 16'hFFFF; bus.reg_ul = 5'd0;
    endtask

    initial begin
        int c, full, len;
        reset = 1'b0;
        set_defaults();
        m_valid = 1'b0; m_win = 1'b0; m_curs = 1'b0; m_k = 0; m_hss = 0; m_fcnt = 0;
        m_byte = 8'h00; m_attr = 8'h00;
        #1;
        check_eq("reset_rgbi", bus.rgbi, 4'h0);
        check_eq("reset_active", bus.active, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        make_pat(8'hA5, 1, 4'hF, 4'h0);
        directed("a5_plain", 8'hA5);

        bus.reg_atr = 1'b1;
        bus.attrbuf[0][0] = 8'h4C;
        make_pat(8'h00, 1, 4'h0, 4'hC);
        directed("attr_rvs", 8'h00);
        bus.reg_rvs = 1'b1;
        bus.reg_bg  = 4'h3;
        make_pat(8'h00, 1, 4'h0, 4'h3);
        directed("attr_rvs_global", 8'h00);
        bus.reg_rvs = 1'b0; bus.reg_bg = 4'h0; bus.reg_atr = 1'b0;

        bus.col = 8'd4; bus.dispaddr = 16'h1000; bus.reg_cp = 16'h1003;
        bus.reg_cm = CM_SOLID; bus.reg_crs = 5'd0; bus.reg_cre = 5'd8; bus.line = 5'd2;
        make_pat(8'h00, 1, 4'h0, 4'hF);
        directed("cursor_on", 8'h00);
        bus.line = 5'd8;
        make_pat(8'h00, 1, 4'h0, 4'h0);
        directed("cursor_off_line", 8'h00);
        bus.reg_cm = CM_OFF; bus.col = 8'd1; bus.line = 5'd0;

        bus.reg_hss = 4'd3;
        make_pat(8'hA5, 1, 4'hF, 4'h0);
        directed("a5_hss3", 8'hA5);

        do_reset();
        bus.reg_hss = 4'd0; bus.reg_dbl = 1'b1;
        make_pat(8'hA5, 2, 4'hF, 4'h0);
        directed("a5_dbl", 8'hA5);

        do_reset();
        bus.reg_dbl = 1'b0; bus.reg_cth = 4'd9; bus.reg_cdh = 4'd8; bus.reg_semi = 1'b1;
        make_pat(8'h01, 1, 4'hF, 4'h0);
        pat.push_back(4'hF);
        pat.push_back(4'h0);
        directed("semi", 8'h01);

        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            bus.reg_cth = 4'($urandom_range(7, 15));
            bus.reg_dbl = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(A_W); i++) begin
                bus.attrbuf[0][i] = 8'($urandom);
                bus.attrbuf[1][i] = 8'($urandom);
            end
            for (int i = 0; i < int'(C_W); i++) bus.charbuf[i] = 8'($urandom);
            repeat (25) begin
                bus.col      = 8'($urandom);
                bus.line     = 5'($urandom_range(0, 15));
                bus.visible  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                bus.rowbuf   = 1'($urandom);
                bus.dispaddr = 16'($urandom);
                c = (int'(bus.col) + 255) % 256;
                bus.reg_cp   = ($urandom_range(0, 2) == 0) ? 16'(bus.dispaddr + 16'(c)) : 16'($urandom);
                bus.reg_cdh  = 4'($urandom_range(0, 15));
                bus.reg_hss  = 4'($urandom_range(0, 15));
                bus.reg_fg   = 4'($urandom);
                bus.reg_bg   = 4'($urandom);
                bus.reg_rvs  = ($urandom_range(0, 3) == 0);
                bus.reg_atr  = 1'($urandom);
                bus.reg_text = 1'($urandom);
                bus.reg_semi = 1'($urandom);
                bus.reg_cbrate = 1'($urandom);
                bus.reg_cm   = cursor_mode_e'($urandom_range(0, 3));
                bus.reg_crs  = 5'($urandom_range(0, 15));
                bus.reg_cre  = 5'($urandom_range(0, 16));
                bus.reg_ul   = ($urandom_range(0, 2) == 0) ? bus.line : 5'($urandom_range(0, 15));
                full = (int'(bus.reg_cth) + 1) * (bus.reg_dbl ? 2 : 1);
                len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, full)) : full;
                step(1'b1, 1'b1, $urandom_range(0, 3) == 0);
                for (int j = 1; j < len; j++) begin
                    if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'($urandom));
                    step(1'b1, 1'b0, $urandom_range(0, 3) == 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
